// File: rtl/offset_pipe_pkg.sv
// Shared definitions for the offset_pipe block.
// Holds the default geometry, the width of the saturation event counter and
// the per-stage payload struct used for the default geometry.
package offset_pipe_pkg;

    localparam int IN_W_DEF           = 10;
    localparam int OUT_W_DEF          = 20;
    localparam int LANES_DEF          = 2;
    localparam int DEPTH_DEF          = 2;
    localparam int OFFSET_DEFAULT_DEF = 110;
    localparam int SATURATE_DEF       = 1;

    // Width of the saturation event counter.
    localparam int SAT_CNT_W = 16;

    // One pipeline beat: all lane results plus one overflow flag per lane.
    typedef struct packed {
        logic [LANES_DEF*OUT_W_DEF-1:0] data;
        logic [LANES_DEF-1:0]           ovf;
    } payload_t;

endpackage

// File: rtl/offset_pipe_if.sv
// Streaming interface of offset_pipe.
// Input channel : in_valid / in_ready / in_data  (producer -> block)
// Output channel: out_valid / out_ready / out_data / out_ovf (block -> consumer)
// Modport slave is the block's view, modport master the environment's view.
interface offset_pipe_if
    import offset_pipe_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int LANES = LANES_DEF
);

    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*IN_W-1:0]  in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*OUT_W-1:0] out_data;
    logic [LANES-1:0]       out_ovf;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_ovf
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_ovf
    );

endinterface

// File: rtl/offset_pipe_stage.sv
// One valid/ready register slice of the offset pipeline.
// Ports:
//   clk, reset       clock and asynchronous active-high reset
//   i_valid, i_data  beat offered by the upstream side
//   i_ready          downstream side can take this slice's beat
//   o_valid, o_data  registered beat held by this slice
// The slice loads when it is empty or when its own beat leaves this cycle.
module offset_pipe_stage
    import offset_pipe_pkg::*;
#(
    parameter type T = payload_t
) (
    input  logic clk,
    input  logic reset,
    input  logic i_valid,
    input  T     i_data,
    input  logic i_ready,
    output logic o_valid,
    output T     o_data
);

    logic r_valid;
    T     r_data;
    logic w_load;

    assign w_load  = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    // Slice register: data only moves with a valid beat, so it stays stable under stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_load) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/offset_pipe.sv
// Multi-lane pipelined offset adder with valid/ready flow control.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   cfg_we       load cfg_offset into the offset register at the clock edge
//   cfg_offset   new offset value
//   cnt_clr      synchronous clear of sat_count (wins over an increment)
//   s_if         streaming in/out channels (slave view)
//   sat_count    number of output transfers with any overflow flag, sticky at all-ones
// Lane arithmetic happens in front of stage 0; later stages only carry the beat.
module offset_pipe
    import offset_pipe_pkg::*;
#(
    parameter int IN_W           = IN_W_DEF,
    parameter int OUT_W          = OUT_W_DEF,
    parameter int LANES          = LANES_DEF,
    parameter int DEPTH          = DEPTH_DEF,
    parameter int OFFSET_DEFAULT = OFFSET_DEFAULT_DEF,
    parameter int SATURATE       = SATURATE_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_we,
    input  logic [OUT_W-1:0]     cfg_offset,
    input  logic                 cnt_clr,
    offset_pipe_if.slave         s_if,
    output logic [SAT_CNT_W-1:0] sat_count
);

    typedef struct packed {
        logic [LANES*OUT_W-1:0] data;
        logic [LANES-1:0]       ovf;
    } stage_t;

    localparam logic [OUT_W-1:0]     OFFSET_INIT = OUT_W'(OFFSET_DEFAULT);
    localparam logic [SAT_CNT_W-1:0] SAT_MAX     = {SAT_CNT_W{1'b1}};

    logic [OUT_W-1:0]     r_offset;
    logic [SAT_CNT_W-1:0] r_sat_count;
    stage_t               w_stage0;
    logic [OUT_W:0]       w_sum;
    logic [DEPTH-1:0]     w_valid;
    stage_t               w_data [DEPTH];
    logic [DEPTH:0]       w_ready;
    logic                 w_xfer_ovf;

    // Zero-extended lane plus offset, with one carry bit to detect overflow.
    function automatic logic [OUT_W:0] lane_sum(input logic [IN_W-1:0]  lane,
                                                input logic [OUT_W-1:0] offset);
        return {{(OUT_W + 1 - IN_W){1'b0}}, lane} + {1'b0, offset};
    endfunction

    // Stage-0 arithmetic: per-lane sum, overflow flag and saturate/wrap result.
    always_comb begin
        w_stage0 = '0;
        w_sum    = '0;
        for (int k = 0; k < LANES; k++) begin
            w_sum = lane_sum(s_if.in_data[k*IN_W +: IN_W], r_offset);
            w_stage0.ovf[k] = w_sum[OUT_W];
            if (w_sum[OUT_W] && (SATURATE != 0)) begin
                w_stage0.data[k*OUT_W +: OUT_W] = {OUT_W{1'b1}};
            end else begin
                w_stage0.data[k*OUT_W +: OUT_W] = w_sum[OUT_W-1:0];
            end
        end
    end

    // Ready chain, walked from the output back to the input so that a
    // returning out_ready reaches in_ready in the same cycle.
    always_comb begin
        w_ready        = '0;
        w_ready[DEPTH] = s_if.out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            w_ready[k] = !w_valid[k] || w_ready[k+1];
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_first
            offset_pipe_stage #(.T(stage_t)) u_stage (
                .clk     (clk),
                .reset   (reset),
                .i_valid (s_if.in_valid),
                .i_data  (w_stage0),
                .i_ready (w_ready[k+1]),
                .o_valid (w_valid[k]),
                .o_data  (w_data[k])
            );
        end else begin : g_rest
            offset_pipe_stage #(.T(stage_t)) u_stage (
                .clk     (clk),
                .reset   (reset),
                .i_valid (w_valid[k-1]),
                .i_data  (w_data[k-1]),
                .i_ready (w_ready[k+1]),
                .o_valid (w_valid[k]),
                .o_data  (w_data[k])
            );
        end
    end

    assign s_if.in_ready  = w_ready[0];
    assign s_if.out_valid = w_valid[DEPTH-1];
    assign s_if.out_data  = w_data[DEPTH-1].data;
    assign s_if.out_ovf   = w_data[DEPTH-1].ovf;
    assign sat_count      = r_sat_count;

    assign w_xfer_ovf = s_if.out_valid && s_if.out_ready && (|s_if.out_ovf);

    // Offset register: a beat accepted on the write edge still sees the old value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_offset <= OFFSET_INIT;
        end else if (cfg_we) begin
            r_offset <= cfg_offset;
        end
    end

    // Saturation event counter: clear has priority, count sticks at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sat_count <= '0;
        end else if (cnt_clr) begin
            r_sat_count <= '0;
        end else if (w_xfer_ovf && (r_sat_count != SAT_MAX)) begin
            r_sat_count <= r_sat_count + {{(SAT_CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule
